cheat_seq: RTL and testbench
============================

CHEAT_SEQ -- requirements
Module: cheat_seq

Interface
REQ-001 Parameter CHEAT_NUM, default 16, number of cheat slots addressed; legal range 1..16.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  1  a cheat entry is offered.
REQ-005 req_ready  output  1  the block accepts the entry this cycle.
REQ-006 req_slot  input  4  target slot index; values >= CHEAT_NUM are accepted and discarded.
REQ-007 req_addr  input  16  CPU match address; bit 15 set = slot enabled.
REQ-008 req_cmp  input  8  compare value.
REQ-009 req_new  input  8  substitute value.
REQ-010 clr_req  input  1  single-cycle pulse requesting disable of all slots.
REQ-011 cpu_m2  input  1  CPU M2 phase; slot registers are written only while low.
REQ-012 wr_en  output  1  slot register write strobe.
REQ-013 wr_slot  output  4  slot index of the write.
REQ-014 wr_reg  output  2  register select: 0 addr lo, 1 addr hi, 2 cmp, 3 new.
REQ-015 wr_data  output  8  write data.
REQ-016 busy  output  1  high whenever the state is not IDLE or a clear is pending.
REQ-017 done  output  1  one-cycle pulse on completion of an entry or of a clear.

Function
REQ-018 States: IDLE, DIS, ALO, CMP, NEW, EN, CLR.
REQ-019 req_ready is 1 only in IDLE with no clear pending and clr_req low.
REQ-020 req_valid & req_ready latches all req_* fields and moves the state to DIS, or to IDLE with no write if req_slot >= CHEAT_NUM (done still pulses next cycle).
REQ-021 Write states, in order, with wr_slot equal to the latched slot:
- DIS: reg 1, data = addr[15:8] & 0x7F.
- ALO: reg 0, data = addr[7:0].
- CMP: reg 2, data = cmp.
- NEW: reg 3, data = new.
- EN: reg 1, data = addr[15:8].
REQ-022 wr_en = (state is a write state or CLR) & !cpu_m2, combinational; a state advances only on a clock edge where wr_en = 1.
REQ-023 While cpu_m2 = 1 the state, outputs wr_slot/wr_reg/wr_data and all counters hold.
REQ-024 After the EN write the state returns to IDLE and done = 1 in the following cycle.
REQ-025 Minimum latency with cpu_m2 held low: accept at cycle 0, writes at cycles 1-5, done at cycle 6, next accept possible at cycle 6.
REQ-026 A clr_req pulse in any state sets clr_pend; clr_pend is served from IDLE and has priority over req_valid when both are present in the same cycle.
REQ-027 CLR writes reg 1 with data 0x00 to slots 0..CHEAT_NUM-1 in ascending order, one slot per wr_en cycle, using a 4-bit counter cleared on entry.
REQ-028 After the write to slot CHEAT_NUM-1: state IDLE, counter 0, clr_pend cleared, done = 1 the next cycle.
REQ-029 clr_req arriving during CLR is absorbed; no second clear is run.
REQ-030 clr_req arriving during an entry sequence does not abort it; the clear starts after EN completes.
REQ-031 Entry data is held from acceptance; later changes on req_* inputs have no effect.

Reset
REQ-032 rst_n = 0 at a clock edge forces: state IDLE, clr_pend 0, counter 0, latched fields 0, wr_en 0, done 0, busy 0, req_ready 0 during reset.
REQ-033 Reset mid-sequence abandons the sequence with no further writes; a slot left disabled by DIS stays disabled.
REQ-034 The first accept is possible on the first clock edge with rst_n = 1.

Verification
REQ-035 cpu_m2 = 0, entry slot 3, addr 0x8123, cmp 0x45, new 0x67 -> writes (3,1,0x01), (3,0,0x23), (3,2,0x45), (3,3,0x67), (3,1,0x81) on cycles 1-5, done on cycle 6.
REQ-036 Same entry with cpu_m2 toggling every cycle -> identical write sequence, wr_en only in cpu_m2 = 0 cycles, done after 10 cycles.
REQ-037 clr_req and req_valid in the same IDLE cycle -> 16 writes (n,1,0x00) for n = 0..15 first, req_ready low until done, then the entry is accepted.
REQ-038 clr_req during the CMP state -> entry completes through EN, then a full clear follows, two done pulses in total.
REQ-039 rst_n low during the ALO state -> wr_en 0 from the next cycle, busy 0, no EN write, and a new entry is accepted after release.
REQ-040 req_slot = 15 with CHEAT_NUM = 8 -> no wr_en and one done pulse.

Source files
------------

// File: rtl/cheat_seq_if.sv
// Cheat-entry request bus and slot-register write port of the cheat sequencer.
interface cheat_seq_if;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_slot;
   logic [15:0] req_addr;
   logic [7:0]  req_cmp;
   logic [7:0]  req_new;
   logic        clr_req;
   logic        cpu_m2;
   logic        wr_en;
   logic [3:0]  wr_slot;
   logic [1:0]  wr_reg;
   logic [7:0]  wr_data;
   logic        busy;
   logic        done;

   modport master (
      output req_valid, req_slot, req_addr, req_cmp, req_new, clr_req, cpu_m2,
      input  req_ready, wr_en, wr_slot, wr_reg, wr_data, busy, done
   );

   modport slave (
      input  req_valid, req_slot, req_addr, req_cmp, req_new, clr_req, cpu_m2,
      output req_ready, wr_en, wr_slot, wr_reg, wr_data, busy, done
   );
endinterface

// File: rtl/cheat_seq.sv
// Cheat slot programming sequencer: disable, write addr/cmp/new, re-enable;
// plus a bulk clear of all slots. Slot writes happen only while CPU M2 is low.
module cheat_seq #(
   parameter int CHEAT_NUM = 16
) (
   input logic       clk,
   input logic       rst_n,
   cheat_seq_if.slave bus
);

   localparam logic [4:0] NUM  = 5'(CHEAT_NUM);
   localparam logic [3:0] LAST = 4'(CHEAT_NUM - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_DIS, S_ALO, S_CMP, S_NEW, S_EN, S_CLR
   } state_t;

   state_t      state_q, state_d;
   logic        clr_pend_q, clr_pend_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  slot_q, slot_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  cmp_q, cmp_d;
   logic [7:0]  new_q, new_d;
   logic        done_q, done_d;

   logic        ready;
   logic        wr_en;
   logic [3:0]  wr_slot;
   logic [1:0]  wr_reg;
   logic [7:0]  wr_data;

   assign ready = rst_n & (state_q == S_IDLE) & ~clr_pend_q & ~bus.clr_req;
   assign wr_en = (state_q != S_IDLE) & ~bus.cpu_m2;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      clr_pend_d = clr_pend_q | (bus.clr_req & (state_q != S_CLR));
      slot_d     = slot_q;
      addr_d     = addr_q;
      cmp_d      = cmp_q;
      new_d      = new_q;
      done_d     = 1'b0;
      wr_slot    = slot_q;
      wr_reg     = 2'd0;
      wr_data    = 8'h00;
      case (state_q)
         S_IDLE: begin
            wr_slot = 4'd0;
            if (clr_pend_q) begin
               state_d = S_CLR;
               cnt_d   = 4'd0;
            end else if (bus.req_valid && ready) begin
               slot_d = bus.req_slot;
               addr_d = bus.req_addr;
               cmp_d  = bus.req_cmp;
               new_d  = bus.req_new;
               // Out-of-range slots are swallowed but still acknowledged with done
               if ({1'b0, bus.req_slot} >= NUM) done_d  = 1'b1;
               else                             state_d = S_DIS;
            end
         end
         S_DIS: begin
            wr_reg  = 2'd1;
            wr_data = addr_q[15:8] & 8'h7F;
            if (wr_en) state_d = S_ALO;
         end
         S_ALO: begin
            wr_reg  = 2'd0;
            wr_data = addr_q[7:0];
            if (wr_en) state_d = S_CMP;
         end
         S_CMP: begin
            wr_reg  = 2'd2;
            wr_data = cmp_q;
            if (wr_en) state_d = S_NEW;
         end
         S_NEW: begin
            wr_reg  = 2'd3;
            wr_data = new_q;
            if (wr_en) state_d = S_EN;
         end
         S_EN: begin
            wr_reg  = 2'd1;
            wr_data = addr_q[15:8];
            if (wr_en) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         S_CLR: begin
            wr_slot = cnt_q;
            wr_reg  = 2'd1;
            wr_data = 8'h00;
            if (wr_en) begin
               if (cnt_q == LAST) begin
                  state_d    = S_IDLE;
                  cnt_d      = 4'd0;
                  clr_pend_d = 1'b0;
                  done_d     = 1'b1;
               end else begin
                  cnt_d = 4'(cnt_q + 4'd1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         clr_pend_q <= 1'b0;
         cnt_q      <= 4'd0;
         slot_q     <= 4'd0;
         addr_q     <= 16'h0000;
         cmp_q      <= 8'h00;
         new_q      <= 8'h00;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_pend_q <= clr_pend_d;
         cnt_q      <= cnt_d;
         slot_q     <= slot_d;
         addr_q     <= addr_d;
         cmp_q      <= cmp_d;
         new_q      <= new_d;
         done_q     <= done_d;
      end
   end

   assign bus.req_ready = ready;
   assign bus.wr_en     = wr_en;
   assign bus.wr_slot   = wr_slot;
   assign bus.wr_reg    = wr_reg;
   assign bus.wr_data   = wr_data;
   assign bus.busy      = (state_q != S_IDLE) | clr_pend_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_cheat_seq.sv
// Directed bench for cheat_seq: entry sequence, M2 stalls, clears, reset, out-of-range slot.
module tb_cheat_seq;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   cheat_seq_if bus();
   cheat_seq_if bus8();

   cheat_seq #(.CHEAT_NUM(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
   cheat_seq #(.CHEAT_NUM(8))  dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

   int tests = 0;
   int fails = 0;
   int cyc;
   int acc_cyc;
   int m2_viol;
   logic [13:0] wq[$];
   int wcyc[$];
   int dcyc[$];

   task automatic begin_seq();
      wq.delete(); wcyc.delete(); dcyc.delete();
      cyc = 0; acc_cyc = -1; m2_viol = 0;
   endtask

   // One cycle: sample at the falling edge, then advance past the rising edge.
   task automatic tick();
      @(negedge clk);
      if (bus.wr_en) begin
         wq.push_back({bus.wr_slot, bus.wr_reg, bus.wr_data});
         wcyc.push_back(cyc);
         if (bus.cpu_m2) m2_viol++;
      end
      if (bus.done) dcyc.push_back(cyc);
      if (bus.req_valid && bus.req_ready) acc_cyc = cyc;
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic set_entry(input logic [3:0] s, input logic [15:0] a,
                            input logic [7:0] c, input logic [7:0] n);
      bus.req_valid = 1'b1; bus.req_slot = s; bus.req_addr = a;
      bus.req_cmp = c; bus.req_new = n;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      set_entry(4'd1, 16'h8001, 8'h01, 8'h02);
      bus8.req_valid = 1'b1;
      begin_seq();
      tick(); tick();
      @(negedge clk);
      tests++; if (bus.wr_en !== 1'b0) begin fails++; $display("FAIL rst_wr_en got %b want 0", bus.wr_en); end
      tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL rst_done got %b want 0", bus.done); end
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b want 0", bus.busy); end
      tests++; if (bus.req_ready !== 1'b0) begin fails++; $display("FAIL rst_ready got %b want 0", bus.req_ready); end
      tests++; if (bus8.req_ready !== 1'b0) begin fails++; $display("FAIL rst_ready8 got %b want 0", bus8.req_ready); end
      @(posedge clk); #1;
      bus.req_valid = 1'b0; bus8.req_valid = 1'b0;
   endtask

   task automatic test_basic();
      logic [13:0] ew [5] = '{{4'd3,2'd1,8'h01}, {4'd3,2'd0,8'h23}, {4'd3,2'd2,8'h45},
                              {4'd3,2'd3,8'h67}, {4'd3,2'd1,8'h81}};
      bus.cpu_m2 = 1'b0;
      set_entry(4'd3, 16'h8123, 8'h45, 8'h67);
      rst_n = 1'b1;
      begin_seq();
      tick();
      // Scribble over the request fields: the latched copy must be used
      set_entry(4'hE, 16'h0000, 8'hFF, 8'hFF);
      bus.req_valid = 1'b0;
      repeat (8) tick();
      tests++; if (acc_cyc != 0) begin fails++; $display("FAIL basic_accept got %0d want 0", acc_cyc); end
      tests++; if (wq.size() != 5) begin fails++; $display("FAIL basic_nwrites got %0d want 5", wq.size()); end
      for (int i = 0; i < 5 && i < wq.size(); i++) begin
         tests++;
         if (wq[i] !== ew[i] || wcyc[i] != i + 1) begin
            fails++; $display("FAIL basic_write%0d got %h@%0d want %h@%0d", i, wq[i], wcyc[i], ew[i], i + 1);
         end
      end
      tests++; if (dcyc.size() != 1 || dcyc[0] != 6) begin fails++; $display("FAIL basic_done got n=%0d first=%0d want n=1 at 6", dcyc.size(), dcyc.size() ? dcyc[0] : -1); end
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL basic_busy_end got %b want 0", bus.busy); end
   endtask

   task automatic test_m2_toggle();
      logic [13:0] ew [5] = '{{4'd3,2'd1,8'h01}, {4'd3,2'd0,8'h23}, {4'd3,2'd2,8'h45},
                              {4'd3,2'd3,8'h67}, {4'd3,2'd1,8'h81}};
      set_entry(4'd3, 16'h8123, 8'h45, 8'h67);
      begin_seq();
      for (int i = 0; i < 14; i++) begin
         bus.cpu_m2 = (i % 2 == 0);
         tick();
         if (i == 0) bus.req_valid = 1'b0;
      end
      bus.cpu_m2 = 1'b0;
      tests++; if (wq.size() != 5) begin fails++; $display("FAIL m2_nwrites got %0d want 5", wq.size()); end
      for (int i = 0; i < 5 && i < wq.size(); i++) begin
         tests++;
         if (wq[i] !== ew[i] || wcyc[i] != 2 * i + 1) begin
            fails++; $display("FAIL m2_write%0d got %h@%0d want %h@%0d", i, wq[i], wcyc[i], ew[i], 2 * i + 1);
         end
      end
      tests++; if (m2_viol != 0) begin fails++; $display("FAIL m2_wr_en_high got %0d want 0", m2_viol); end
      tests++; if (dcyc.size() != 1 || dcyc[0] != 10) begin fails++; $display("FAIL m2_done got n=%0d first=%0d want n=1 at 10", dcyc.size(), dcyc.size() ? dcyc[0] : -1); end
   endtask

   task automatic test_clr_priority();
      logic [13:0] ew [21];
      int ec [21];
      for (int n = 0; n < 16; n++) begin ew[n] = {4'(n), 2'd1, 8'h00}; ec[n] = 2 + n; end
      ew[16] = {4'd5,2'd1,8'h0A}; ew[17] = {4'd5,2'd0,8'hBC}; ew[18] = {4'd5,2'd2,8'h11};
      ew[19] = {4'd5,2'd3,8'h22}; ew[20] = {4'd5,2'd1,8'h8A};
      for (int n = 16; n < 21; n++) ec[n] = 19 + (n - 16);
      bus.cpu_m2 = 1'b0;
      set_entry(4'd5, 16'h8ABC, 8'h11, 8'h22);
      bus.clr_req = 1'b1;
      begin_seq();
      tick();
      bus.clr_req = 1'b0;
      while (cyc < 27) begin
         if (cyc == 19) bus.req_valid = 1'b0;
         tick();
      end
      tests++; if (acc_cyc != 18) begin fails++; $display("FAIL clrprio_accept got %0d want 18", acc_cyc); end
      tests++; if (wq.size() != 21) begin fails++; $display("FAIL clrprio_nwrites got %0d want 21", wq.size()); end
      for (int i = 0; i < 21 && i < wq.size(); i++) begin
         tests++;
         if (wq[i] !== ew[i] || wcyc[i] != ec[i]) begin
            fails++; $display("FAIL clrprio_write%0d got %h@%0d want %h@%0d", i, wq[i], wcyc[i], ew[i], ec[i]);
         end
      end
      tests++; if (dcyc.size() != 2 || dcyc[0] != 18 || dcyc[1] != 24) begin fails++; $display("FAIL clrprio_done got n=%0d want 2 at 18,24", dcyc.size()); end
   endtask

   task automatic test_clr_during_entry();
      logic [13:0] ew [21];
      int ec [21];
      ew[0] = {4'd2,2'd1,8'h00}; ew[1] = {4'd2,2'd0,8'h55}; ew[2] = {4'd2,2'd2,8'h66};
      ew[3] = {4'd2,2'd3,8'h77}; ew[4] = {4'd2,2'd1,8'h80};
      for (int n = 0; n < 5; n++) ec[n] = 1 + n;
      for (int n = 0; n < 16; n++) begin ew[5 + n] = {4'(n), 2'd1, 8'h00}; ec[5 + n] = 7 + n; end
      bus.cpu_m2 = 1'b0;
      set_entry(4'd2, 16'h8055, 8'h66, 8'h77);
      begin_seq();
      while (cyc < 32) begin
         if (cyc == 1) bus.req_valid = 1'b0;
         // Pulse once during CMP, and once more mid-clear where it must be absorbed
         bus.clr_req = (cyc == 3) || (cyc == 10);
         tick();
      end
      bus.clr_req = 1'b0;
      tests++; if (wq.size() != 21) begin fails++; $display("FAIL clrcmp_nwrites got %0d want 21", wq.size()); end
      for (int i = 0; i < 21 && i < wq.size(); i++) begin
         tests++;
         if (wq[i] !== ew[i] || wcyc[i] != ec[i]) begin
            fails++; $display("FAIL clrcmp_write%0d got %h@%0d want %h@%0d", i, wq[i], wcyc[i], ew[i], ec[i]);
         end
      end
      tests++; if (dcyc.size() != 2 || dcyc[0] != 6 || dcyc[1] != 23) begin fails++; $display("FAIL clrcmp_done got n=%0d want 2 at 6,23", dcyc.size()); end
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL clrcmp_busy_end got %b want 0", bus.busy); end
   endtask

   task automatic test_reset_mid();
      logic [13:0] ew [7] = '{{4'd7,2'd1,8'h10}, {4'd7,2'd0,8'h01},
                              {4'd1,2'd1,8'h00}, {4'd1,2'd0,8'h02}, {4'd1,2'd2,8'h03},
                              {4'd1,2'd3,8'h04}, {4'd1,2'd1,8'h80}};
      int ec [7] = '{1, 2, 5, 6, 7, 8, 9};
      bus.cpu_m2 = 1'b0;
      set_entry(4'd7, 16'h9001, 8'h01, 8'h02);
      begin_seq();
      while (cyc < 12) begin
         if (cyc == 1) bus.req_valid = 1'b0;
         if (cyc == 2) rst_n = 1'b0;
         if (cyc == 3) begin
            tests++; if (bus.wr_en !== 1'b0) begin fails++; $display("FAIL rstmid_wr_en got %b want 0", bus.wr_en); end
            tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
         end
         if (cyc == 4) begin rst_n = 1'b1; set_entry(4'd1, 16'h8002, 8'h03, 8'h04); end
         if (cyc == 5) bus.req_valid = 1'b0;
         tick();
      end
      tests++; if (acc_cyc != 4) begin fails++; $display("FAIL rstmid_accept got %0d want 4", acc_cyc); end
      tests++; if (wq.size() != 7) begin fails++; $display("FAIL rstmid_nwrites got %0d want 7", wq.size()); end
      for (int i = 0; i < 7 && i < wq.size(); i++) begin
         tests++;
         if (wq[i] !== ew[i] || wcyc[i] != ec[i]) begin
            fails++; $display("FAIL rstmid_write%0d got %h@%0d want %h@%0d", i, wq[i], wcyc[i], ew[i], ec[i]);
         end
      end
      tests++; if (dcyc.size() != 1 || dcyc[0] != 10) begin fails++; $display("FAIL rstmid_done got n=%0d want 1 at 10", dcyc.size()); end
   endtask

   task automatic test_slots8();
      int nw = 0, nd = 0, dc = -1, bad = 0;
      bus8.cpu_m2 = 1'b0; bus8.req_valid = 1'b1; bus8.req_slot = 4'd15;
      bus8.req_addr = 16'h8FFF; bus8.req_cmp = 8'hAA; bus8.req_new = 8'h55;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus8.wr_en) nw++;
         if (bus8.done) begin nd++; dc = c; end
         @(posedge clk); #1;
         if (c == 0) bus8.req_valid = 1'b0;
      end
      tests++; if (nw != 0) begin fails++; $display("FAIL oob_writes got %0d want 0", nw); end
      tests++; if (nd != 1 || dc != 1) begin fails++; $display("FAIL oob_done got n=%0d at %0d want 1 at 1", nd, dc); end
      nw = 0; nd = 0; dc = -1;
      bus8.clr_req = 1'b1;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         if (bus8.wr_en) begin
            if (bus8.wr_slot != 4'(nw) || bus8.wr_reg != 2'd1 || bus8.wr_data != 8'h00 || c != 2 + nw) bad++;
            nw++;
         end
         if (bus8.done) begin nd++; dc = c; end
         @(posedge clk); #1;
         bus8.clr_req = 1'b0;
      end
      tests++; if (nw != 8) begin fails++; $display("FAIL clr8_nwrites got %0d want 8", nw); end
      tests++; if (bad != 0) begin fails++; $display("FAIL clr8_order got %0d bad writes want 0", bad); end
      tests++; if (nd != 1 || dc != 10) begin fails++; $display("FAIL clr8_done got n=%0d at %0d want 1 at 10", nd, dc); end
   endtask

   initial begin
      rst_n = 1'b0;
      bus.req_valid = 1'b0; bus.req_slot = '0; bus.req_addr = '0; bus.req_cmp = '0;
      bus.req_new = '0; bus.clr_req = 1'b0; bus.cpu_m2 = 1'b0;
      bus8.req_valid = 1'b0; bus8.req_slot = '0; bus8.req_addr = '0; bus8.req_cmp = '0;
      bus8.req_new = '0; bus8.clr_req = 1'b0; bus8.cpu_m2 = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_basic();
      test_m2_toggle();
      test_clr_priority();
      test_clr_during_entry();
      test_reset_mid();
      test_slots8();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
